// File: rtl/cpu_mem_responder.sv
// Word-organised dual-port RAM responder for the CPU fetch and load/store ports, 1-cycle registered reads.
// Optional board I/O window (LEDs, synchronised switches) is enabled by defining MEM_MMIO_EN.
module cpu_mem_responder #(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [15:0] MMIO_BASE = 16'hFF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_pc_addr,
  input  logic        i_pc_rd,
  output logic [15:0] o_pc_rddata,
  output logic        o_pc_rdvalid,
  input  logic [15:0] i_ldst_addr,
  input  logic        i_ldst_rd,
  input  logic        i_ldst_wr,
  input  logic [15:0] i_ldst_wrdata,
  output logic [15:0] o_ldst_rddata,
  output logic        o_ldst_rdvalid,
  output logic        o_err,
  output logic [7:0]  o_err_count,
  input  logic [15:0] i_switches,
  output logic [15:0] o_leds
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned BYTES = 2 * DEPTH;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] pc_idx, ls_idx;
  logic          pc_in, ls_in, pc_ok, ls_ok, ls_mmio;
  logic          ram_we, fwd, err_d;
  logic [15:0]   pc_rddata_d, ls_rddata_d, mmio_rddata;

  logic [15:0] pc_rddata_q, ls_rddata_q;
  logic        pc_rdvalid_q, ls_rdvalid_q, err_q;
  logic [7:0]  err_count_q;

  assign pc_idx = i_pc_addr[AW:1];
  assign ls_idx = i_ldst_addr[AW:1];
  assign pc_in  = 32'(i_pc_addr) < BYTES;
  assign ls_in  = 32'(i_ldst_addr) < BYTES;

`ifdef MEM_MMIO_EN
  localparam logic [15:0] SW_ADDR = MMIO_BASE + 16'd2;

  logic [15:0] leds_q, sw_meta_q, sw_sync_q;
  logic        pc_mmio;

  assign ls_mmio = (i_ldst_addr >= MMIO_BASE) && (32'(i_ldst_addr) <= 32'(MMIO_BASE) + 32'hFF);
  assign pc_mmio = (i_pc_addr >= MMIO_BASE) && (32'(i_pc_addr) <= 32'(MMIO_BASE) + 32'hFF);
  // Instruction fetch from the I/O window is treated as an error, never a read.
  assign pc_ok   = pc_in && !pc_mmio;

  always_comb begin
    mmio_rddata = 16'h0000;
    if (i_ldst_addr[15:1] == MMIO_BASE[15:1])
      mmio_rddata = leds_q;
    else if (i_ldst_addr[15:1] == SW_ADDR[15:1])
      mmio_rddata = sw_sync_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds_q    <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= i_switches;
      sw_sync_q <= sw_meta_q;
      if (i_ldst_wr && ls_mmio && i_ldst_addr[15:1] == MMIO_BASE[15:1])
        leds_q <= i_ldst_wrdata;
    end
  end

  assign o_leds = leds_q;
`else
  logic unused_mmio;

  assign ls_mmio     = 1'b0;
  assign pc_ok       = pc_in;
  assign mmio_rddata = 16'h0000;
  assign o_leds      = 16'h0000;
  assign unused_mmio = ^{i_switches, MMIO_BASE};
`endif

  assign ls_ok  = ls_in || ls_mmio;
  assign ram_we = i_ldst_wr && ls_in && !ls_mmio && !reset;
  assign fwd    = ram_we && (pc_idx == ls_idx);
  assign err_d  = (i_pc_rd && !pc_ok) || ((i_ldst_rd || i_ldst_wr) && !ls_ok);

  always_comb begin
    pc_rddata_d = 16'h0000;
    ls_rddata_d = 16'h0000;
    if (pc_ok)
      pc_rddata_d = fwd ? i_ldst_wrdata : mem[pc_idx];
    // Load sees the pre-write word when a store hits the same cycle.
    if (ls_mmio)
      ls_rddata_d = mmio_rddata;
    else if (ls_in)
      ls_rddata_d = mem[ls_idx];
  end

  always_ff @(posedge clk) begin
    if (ram_we)
      mem[ls_idx] <= i_ldst_wrdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_rddata_q  <= '0;
      pc_rdvalid_q <= 1'b0;
      ls_rddata_q  <= '0;
      ls_rdvalid_q <= 1'b0;
      err_q        <= 1'b0;
      err_count_q  <= '0;
    end else begin
      pc_rdvalid_q <= i_pc_rd;
      ls_rdvalid_q <= i_ldst_rd;
      err_q        <= err_d;
      if (i_pc_rd)
        pc_rddata_q <= pc_rddata_d;
      if (i_ldst_rd)
        ls_rddata_q <= ls_rddata_d;
      if (err_d && err_count_q != 8'hFF)
        err_count_q <= err_count_q + 8'd1;
    end
  end

  assign o_pc_rddata    = pc_rddata_q;
  assign o_pc_rdvalid   = pc_rdvalid_q;
  assign o_ldst_rddata  = ls_rddata_q;
  assign o_ldst_rdvalid = ls_rdvalid_q;
  assign o_err          = err_q;
  assign o_err_count    = err_count_q;
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: stimulus queues expected read data, a negedge monitor checks it.
module tb_cpu_mem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] i_pc_addr, o_pc_rddata, i_ldst_addr, i_ldst_wrdata, o_ldst_rddata;
  logic [15:0] i_switches, o_leds;
  logic        i_pc_rd, o_pc_rdvalid, i_ldst_rd, i_ldst_wr, o_ldst_rdvalid, o_err;
  logic [7:0]  o_err_count;

  logic [15:0] pc_q[$];
  logic [15:0] ls_q[$];
  int vectors = 0;
  int miscompares = 0;
  int exp_cnt = 0;

  cpu_mem_responder dut (
    .clk(clk), .reset(reset),
    .i_pc_addr(i_pc_addr), .i_pc_rd(i_pc_rd),
    .o_pc_rddata(o_pc_rddata), .o_pc_rdvalid(o_pc_rdvalid),
    .i_ldst_addr(i_ldst_addr), .i_ldst_rd(i_ldst_rd), .i_ldst_wr(i_ldst_wr),
    .i_ldst_wrdata(i_ldst_wrdata),
    .o_ldst_rddata(o_ldst_rddata), .o_ldst_rdvalid(o_ldst_rdvalid),
    .o_err(o_err), .o_err_count(o_err_count),
    .i_switches(i_switches), .o_leds(o_leds)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (o_pc_rdvalid) begin
        if (pc_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL pc_unexpected_valid: got data %h with nothing expected", o_pc_rddata);
        end else check("pc_rddata", o_pc_rddata, pc_q.pop_front());
      end
      if (o_ldst_rdvalid) begin
        if (ls_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL ldst_unexpected_valid: got data %h with nothing expected", o_ldst_rddata);
        end else check("ldst_rddata", o_ldst_rddata, ls_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    i_pc_rd = 1'b0; i_ldst_rd = 1'b0; i_ldst_wr = 1'b0;
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d);
    i_ldst_addr = a; i_ldst_wrdata = d; i_ldst_wr = 1'b1; step();
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] exp);
    i_ldst_addr = a; i_ldst_rd = 1'b1; ls_q.push_back(exp); step();
  endtask

  task automatic fetch(input logic [15:0] a, input logic [15:0] exp);
    i_pc_addr = a; i_pc_rd = 1'b1; pc_q.push_back(exp); step();
  endtask

  task automatic check_err(input string name, input logic exp_err);
    check({name, "_err"}, {15'd0, o_err}, {15'd0, exp_err});
    check({name, "_err_count"}, {8'd0, o_err_count}, exp_cnt[15:0]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    i_pc_addr = '0; i_pc_rd = 1'b0; i_ldst_addr = '0; i_ldst_rd = 1'b0;
    i_ldst_wr = 1'b0; i_ldst_wrdata = '0; i_switches = 16'h0003;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc_rdvalid", {15'd0, o_pc_rdvalid}, 16'h0);
    check("rst_ldst_rdvalid", {15'd0, o_ldst_rdvalid}, 16'h0);
    check("rst_pc_rddata", o_pc_rddata, 16'h0);
    check("rst_ldst_rddata", o_ldst_rddata, 16'h0);
    check("rst_leds", o_leds, 16'h0);
    check_err("rst", 1'b0);
    reset = 1'b0;

    // Store then load, with exact 1-cycle latency and hold-when-idle.
    store(16'h0010, 16'hBEEF);
    load(16'h0010, 16'hBEEF);
    check("lat_ldst_rdvalid", {15'd0, o_ldst_rdvalid}, 16'h1);
    check("lat_ldst_rddata", o_ldst_rddata, 16'hBEEF);
    step();
    check("idle_ldst_rdvalid", {15'd0, o_ldst_rdvalid}, 16'h0);
    check("idle_ldst_hold", o_ldst_rddata, 16'hBEEF);

    // Store on ldst forwarded to a same-cycle fetch of that word.
    i_ldst_addr = 16'h0020; i_ldst_wrdata = 16'h1234; i_ldst_wr = 1'b1;
    i_pc_addr = 16'h0021; i_pc_rd = 1'b1; pc_q.push_back(16'h1234);
    step();
    fetch(16'h0020, 16'h1234);

    // Read-first on simultaneous load+store.
    store(16'h0030, 16'h5555);
    i_ldst_addr = 16'h0030; i_ldst_wrdata = 16'hAAAA; i_ldst_wr = 1'b1; i_ldst_rd = 1'b1;
    ls_q.push_back(16'h5555);
    step();
    load(16'h0030, 16'hAAAA);

    // Back-to-back reads on both ports every cycle.
    for (int i = 0; i < 8; i++) store(16'h0100 + 16'(2 * i), 16'hA000 + 16'(i));
    for (int i = 0; i < 8; i++) begin
      i_pc_addr = 16'h0100 + 16'(2 * i); i_pc_rd = 1'b1; pc_q.push_back(16'hA000 + 16'(i));
      i_ldst_addr = 16'h010E - 16'(2 * i); i_ldst_rd = 1'b1; ls_q.push_back(16'hA007 - 16'(i));
      step();
    end

    // Top of the RAM is in range.
    store(16'h1FFE, 16'hCAFE);
    load(16'h1FFF, 16'hCAFE);
    check_err("top_in_range", 1'b0);

    // Out-of-range store is dropped, not aliased onto word 0.
    store(16'h0000, 16'h1111);
    store(16'h2000, 16'h7777);
    exp_cnt++;
    check_err("oob_store", 1'b1);
    step();
    check_err("err_pulse_end", 1'b0);
    load(16'h0000, 16'h1111);
    load(16'h2000, 16'h0000);
    exp_cnt++;
    check_err("oob_load", 1'b1);

    // Both ports out of range in one cycle count once.
    i_pc_addr = 16'h3000; i_pc_rd = 1'b1; pc_q.push_back(16'h0000);
    i_ldst_addr = 16'hFFFE; i_ldst_rd = 1'b1; ls_q.push_back(16'h0000);
    step();
    exp_cnt++;
    check_err("oob_both", 1'b1);

`ifdef MEM_MMIO_EN
    store(16'hFF00, 16'h00F0);
    check("mmio_leds", o_leds, 16'h00F0);
    check_err("mmio_store", 1'b0);
    load(16'hFF02, 16'h0003);
    load(16'hFF00, 16'h00F0);
    load(16'hFF10, 16'h0000);
    check_err("mmio_other", 1'b0);
    store(16'hFF04, 16'h9999);
    check_err("mmio_drop", 1'b0);
    fetch(16'hFF00, 16'h0000);
    exp_cnt++;
    check_err("mmio_fetch", 1'b1);
`else
    load(16'hFF00, 16'h0000);
    exp_cnt++;
    check_err("nommio_load", 1'b1);
    store(16'hFF00, 16'h00F0);
    exp_cnt++;
    check_err("nommio_store", 1'b1);
    check("nommio_leds", o_leds, 16'h0000);
`endif

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) fetch(16'h4000, 16'h0000);
    exp_cnt = 255;
    check_err("saturate", 1'b1);

    // Async reset while fetches stream; RAM survives.
    fetch(16'h0010, 16'hBEEF);
    i_pc_addr = 16'h0010; i_pc_rd = 1'b1; pc_q.push_back(16'hBEEF);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("arst_pc_rdvalid", {15'd0, o_pc_rdvalid}, 16'h0);
    exp_cnt = 0;
    check_err("arst", 1'b0);
    pc_q.delete();
    @(posedge clk); #1;
    i_pc_rd = 1'b0;
    reset = 1'b0;
    load(16'h0010, 16'hBEEF);
    fetch(16'h0010, 16'hBEEF);

    repeat (3) step();
    check("pending_pc", 16'(pc_q.size()), 16'h0);
    check("pending_ldst", 16'(ls_q.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
